ram_burst_reader: RTL

//   Sequential burst-read engine for one port of the dual-port ram_block (2-stage, ce-gated read pipeline).
//   On a start pulse it reads LENGTH consecutive words from BASE_ADDR, wrapping at MEM_SIZE.
//   It presents them as a valid/ready stream with a last flag.
//   It stalls the RAM pipeline through ce, so no skid buffer is needed and it sustains 1 word/cycle.
//   It sits directly downstream of ram_block and feeds compute stages that consume buffered weights or activations.

---
 rtl/ram_burst_reader.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst-read engine for one port of a 2-stage, ce-gated RAM. Streams LENGTH words
// from BASE_ADDR (wrapping at MEM_SIZE) as valid/ready/last, stalling the RAM through ce.
module ram_burst_reader #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 13,
  parameter int MEM_SIZE = 3072,
  parameter int LWIDTH   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_out_valid,
  output logic              data_out_last,
  input  logic              data_out_ready
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [AWIDTH-1:0]   addr_reg;
  logic [LWIDTH-1:0]   remaining_reg;
  logic [STAGES-1:0]   vld_reg, lst_reg;
  logic                done_reg;
  logic                issue;
  logic                issue_last;
  logic                drain_empty;

  assign issue       = (state_reg == BUSY) && (remaining_reg != '0);
  assign issue_last  = issue && (remaining_reg == LWIDTH'(1));
  // The RAM only advances when the output slot is empty or being consumed,
  // which makes the RAM's own registers act as the stream buffer.
  assign ram_ce      = (state_reg != IDLE) && (!vld_reg[STAGES-1] || data_out_ready);
  assign drain_empty = (vld_reg == '0) || (lst_reg[STAGES-1] && data_out_ready);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = BUSY;
      BUSY:  if (remaining_reg == '0 || (ram_ce && issue_last)) state_next = DRAIN;
      DRAIN: if (drain_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == DRAIN) && (state_next == IDLE);
      if (state_reg == IDLE && start) begin
        addr_reg      <= base_addr;
        remaining_reg <= length;
      end else if (issue && ram_ce) begin
        addr_reg      <= (addr_reg == AWIDTH'(MEM_SIZE - 1)) ? '0 : addr_reg + AWIDTH'(1);
        remaining_reg <= remaining_reg - LWIDTH'(1);
      end
    end
  end

  // Valid/last tags shadow the RAM read stages and shift only with ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg[0] <= 1'b0;
      lst_reg[0] <= 1'b0;
    end else if (ram_ce) begin
      vld_reg[0] <= issue;
      lst_reg[0] <= issue_last;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_reg[gi] <= 1'b0;
          lst_reg[gi] <= 1'b0;
        end else if (ram_ce) begin
          vld_reg[gi] <= vld_reg[gi-1];
          lst_reg[gi] <= lst_reg[gi-1];
        end
      end
    end
  endgenerate

  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign ram_addr       = addr_reg;
  assign ram_we         = 1'b0;
  assign ram_d          = '0;
  assign data_out       = ram_q;
  assign data_out_valid = vld_reg[STAGES-1];
  assign data_out_last  = lst_reg[STAGES-1];

endmodule
